// File: rtl/instruction_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared constants and types for the fetch stage and the execute core.
//   XLEN        : architectural register / PC width
//   INSTR_NOP   : canonical NOP (addi x0, x0, 0), shown when nothing was fetched
//   PC_STEP     : byte increment between sequential instructions
//   fetch_entry_t : one queued fetch result, {pc, word}
//   align_pc()  : clears the byte-offset bits of a PC
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fetch_entry_t;

    // Instructions are word aligned; the low two bits of a target are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if
// Bundles every signal the fetch stage exchanges with the core and with the
// program memory.
//   redirect_valid/redirect_pc : new PC request from the core
//   imem_rd_en/imem_addr       : read strobe and word address to program memory
//   imem_rdata                 : read data, one cycle after imem_rd_en
//   instr_valid/instr/instr_pc : queue head presented to the core
//   instr_ready                : core accepts the head
// Modports: master = fetch stage, slave = core/memory side.
// ---------------------------------------------------------------------------
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = 8
);
    import instruction_fetch_pkg::*;

    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;
    logic                  imem_rd_en;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [XLEN-1:0]       imem_rdata;
    logic                  instr_valid;
    logic [XLEN-1:0]       instr;
    logic [XLEN-1:0]       instr_pc;
    logic                  instr_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, instr_ready,
        output imem_rd_en, imem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, instr_ready,
        input  imem_rd_en, imem_addr, instr_valid, instr, instr_pc
    );

endinterface

// File: rtl/instruction_fetch_fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Two-entry synchronous FIFO of {pc, word}. Entry 0 is always the head, so
// the head output comes straight from a register.
//   clk, reset : clock, synchronous active-low reset
//   push, push_entry : write a new entry at the tail
//   pop        : discard the head (ignored when empty)
//   flush      : empty the queue; overrides push and pop
//   count      : number of valid entries, 0..2
//   head       : entry 0; keeps its last value once the queue drains
// ---------------------------------------------------------------------------
module fetch_queue
    import instruction_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    localparam fetch_entry_t RESET_ENTRY = '{pc: '0, word: INSTR_NOP};

    fetch_entry_t entry0_q, entry0_d;
    fetch_entry_t entry1_q, entry1_d;
    logic [1:0]   count_q, count_d;
    logic         pop_eff;
    logic         push_eff;

    // A pop that empties the queue leaves entry 0 untouched so the head holds
    // its last value. A push lands in the first slot free after this cycle's pop.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        pop_eff  = pop & (count_q != 2'd0);
        push_eff = push & ((count_q != 2'd2) | pop_eff);
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop_eff && (count_q == 2'd2)) begin
                entry0_d = entry1_q;
            end
            if (push_eff) begin
                if ((count_q - {1'b0, pop_eff}) == 2'd0) begin
                    entry0_d = push_entry;
                end else begin
                    entry1_d = push_entry;
                end
            end
            count_d = count_q + {1'b0, push_eff} - {1'b0, pop_eff};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            entry0_q <= RESET_ENTRY;
            entry1_q <= RESET_ENTRY;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = entry0_q;

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// Fetch stage ahead of the single-cycle core. Owns the PC, reads a
// synchronous program memory (1-cycle latency), buffers results in a
// 2-entry queue and hands them to the core with valid/ready. A redirect
// from the core flushes the queue and drops the in-flight read.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : instruction_fetch_if.master (redirect, imem, instr handshake)
// ---------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            inflight_q, inflight_d;

    logic [1:0]      q_count;
    fetch_entry_t    q_head;
    fetch_entry_t    push_entry;
    logic            instr_valid;
    logic            pop;
    logic            push;
    logic            issue;

    assign instr_valid = (q_count != 2'd0);

    // Issue only while the queue has a slot reserved for every outstanding
    // read, counting the slot freed by this cycle's handshake. This is what
    // keeps the queue from ever overflowing.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        pop        = instr_valid & bus.instr_ready;
        issue      = reset & ~bus.redirect_valid &
                     (({1'b0, q_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
        push       = inflight_q & reset & ~bus.redirect_valid;
        push_entry = '{pc: pend_pc_q, word: bus.imem_rdata};
        inflight_d = issue;
        if (bus.redirect_valid) begin
            fetch_pc_d = align_pc(bus.redirect_pc);
        end else if (issue) begin
            pend_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_queue u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (bus.redirect_valid),
        .count      (q_count),
        .head       (q_head)
    );

    assign bus.imem_rd_en  = issue;
    assign bus.imem_addr   = fetch_pc_q[ADDR_WIDTH+1:2];
    assign bus.instr_valid = instr_valid;
    assign bus.instr       = q_head.word;
    assign bus.instr_pc    = q_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch. Expected {pc, word} deliveries are
// queued by the stimulus; a monitor pops and compares on each handshake.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic clk;
    logic reset;

    instruction_fetch_if #(.ADDR_WIDTH(8)) bus ();

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .ADDR_WIDTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [256];
    logic [63:0] exp_q [$];
    int vectors;
    int miscompares;

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory model: one-cycle synchronous read
    always @(posedge clk) begin
        if (bus.imem_rd_en) bus.imem_rdata <= mem[bus.imem_addr];
    end

    // Word stored at a byte PC: addi x1, x0, <word index>
    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        logic [31:0] idx;
        idx = (pc >> 2) & 32'h0000_00FF;
        return (idx << 20) | 32'h0000_0093;
    endfunction

    // Monitor: every completed handshake is compared with the oldest expectation
    always @(negedge clk) begin
        if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL deliver_unexpected: got pc=%h word=%h, required no delivery",
                         bus.instr_pc, bus.instr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({bus.instr_pc, bus.instr} !== e) begin
                    miscompares++;
                    $display("[TB] FAIL deliver: got pc=%h word=%h, required pc=%h word=%h",
                             bus.instr_pc, bus.instr, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start_pc, input int n);
        logic [31:0] pc;
        pc = start_pc;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({pc, mem_word(pc)});
            pc = pc + 32'd4;
        end
    endtask

    // One low cycle of reset, check reset values, then release with given ready
    task automatic apply_reset(input logic rdy);
        reset = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        cyc(1);
        check_output("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check_output("rst_instr", bus.instr, 32'h0000_0013);
        check_output("rst_pc", bus.instr_pc, 32'd0);
        check_output("rst_rd_en", {31'd0, bus.imem_rd_en}, 32'd0);
        check_output("rst_addr", {24'd0, bus.imem_addr}, 32'd0);
        reset = 1'b1;
        bus.instr_ready = rdy;
        #1;
        check_output("rel_rd_en", {31'd0, bus.imem_rd_en}, 32'd1);
        check_output("rel_addr", {24'd0, bus.imem_addr}, 32'd0);
    endtask

    // Redirect in cycle R, then take n instructions from the aligned target
    task automatic apply_stimulus_redirect(input logic [31:0] target, input int n, input logic rdy_r);
        logic [31:0] aligned;
        aligned = target & 32'hFFFF_FFFC;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = target;
        bus.instr_ready = rdy_r;
        #1;
        check_output("redir_no_issue", {31'd0, bus.imem_rd_en}, 32'd0);
        cyc(1);
        bus.redirect_valid = 1'b0;
        bus.instr_ready = 1'b1;
        expect_seq(aligned, n);
        #1;
        check_output("redir_r1_valid", {31'd0, bus.instr_valid}, 32'd0);
        check_output("redir_r1_rd_en", {31'd0, bus.imem_rd_en}, 32'd1);
        check_output("redir_r1_addr", {24'd0, bus.imem_addr}, (aligned >> 2) & 32'h0000_00FF);
        cyc(1);
        check_output("redir_r2_valid", {31'd0, bus.instr_valid}, 32'd0);
        cyc(1);
        check_output("redir_r3_valid", {31'd0, bus.instr_valid}, 32'd1);
        check_output("redir_r3_pc", bus.instr_pc, aligned);
        cyc(n);
        bus.instr_ready = 1'b0;
    endtask

    task automatic drain_check(input string name);
        bus.instr_ready = 1'b0;
        cyc(3);
        check_output(name, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 256; i++) mem[i] = mem_word(i << 2);
        reset = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.instr_ready = 1'b0;
        bus.imem_rdata = 32'd0;
        cyc(1);

        // Streaming from reset: 0,4,8,12,16 back to back
        apply_reset(1'b1);
        expect_seq(32'd0, 5);
        cyc(7);
        bus.instr_ready = 1'b0;
        drain_check("stream_drained");

        // Backpressure: head held at PC 0, issue stopped, then 0,4,8 in order
        apply_reset(1'b0);
        expect_seq(32'd0, 3);
        cyc(6);
        check_output("bp_valid", {31'd0, bus.instr_valid}, 32'd1);
        check_output("bp_pc", bus.instr_pc, 32'd0);
        check_output("bp_instr", bus.instr, mem_word(32'd0));
        check_output("bp_rd_en", {31'd0, bus.imem_rd_en}, 32'd0);
        bus.instr_ready = 1'b1;
        cyc(3);
        bus.instr_ready = 1'b0;
        drain_check("bp_drained");

        // Redirect to 0x40 with queue holding PC 0 and PC 4 in flight
        apply_reset(1'b0);
        cyc(2);
        check_output("pre_redir_pc", bus.instr_pc, 32'd0);
        apply_stimulus_redirect(32'h0000_0040, 1, 1'b0);
        // Misaligned target and wrap past the top of the address space
        apply_stimulus_redirect(32'h0000_0043, 2, 1'b0);
        apply_stimulus_redirect(32'hFFFF_FFFC, 2, 1'b0);
        drain_check("redir_drained");

        // Reset mid-stream restarts delivery at the reset PC
        apply_reset(1'b1);
        expect_seq(32'd0, 2);
        cyc(4);
        apply_reset(1'b1);
        expect_seq(32'd0, 3);
        cyc(5);
        bus.instr_ready = 1'b0;
        drain_check("midrst_drained");

        // Redirect in the same cycle as a completed handshake of PC 4
        apply_reset(1'b1);
        expect_seq(32'd0, 2);
        cyc(3);
        apply_stimulus_redirect(32'h0000_0080, 2, 1'b1);
        drain_check("hs_redir_drained");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
